// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: direct-mapped 16-line write-back L1 cache controller.
// A miss writes back a dirty victim to L2, then fetches the line from L2,
// or from memory if L2 misses. The access completes through a second LOOKUP.
// Optional build macro L1_STATS_EN adds saturating hit_cnt / miss_cnt outputs.
module l1_cache_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_rd,
    input  logic         cpu_wr,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         cpu_stall,
    output logic         read_from_L2,
    output logic         write_to_L2,
    output logic [31:0]  l2_addr,
    output logic [127:0] l2_wdata,
    input  logic [127:0] l2_rdata,
    input  logic         l2_hit,
    input  logic         l2_miss,
    input  logic         l2_wack,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack
`ifdef L1_STATS_EN
    ,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        EVICT   = 3'd2,
        FETCH   = 3'd3,
        MEMFILL = 3'd4
    } state_t;

    state_t         state_r, state_s;
    logic [31:0]    req_addr_r;
    logic [31:0]    req_wdata_r;
    logic           req_wr_r;
    logic [15:0]    valid_r;
    logic [15:0]    dirty_r;
    logic [25:0]    tag_r  [16];
    logic [127:0]   data_r [16];

    logic [25:0]    req_tag_s;
    logic [3:0]     req_idx_s;
    logic [6:0]     req_bit_s;
    logic           hit_s;
    logic           rd_hit_s;
    logic           wr_hit_s;
    logic           evict_done_s;
    logic           install_s;
    logic [127:0]   fill_s;

    assign req_tag_s = req_addr_r[31:6];
    assign req_idx_s = req_addr_r[5:2];
    assign req_bit_s = {req_addr_r[1:0], 5'b00000};
    assign hit_s     = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);

    // Next-state decode plus the one-cycle action strobes of each state
    always_comb begin
        state_s      = state_r;
        rd_hit_s     = 1'b0;
        wr_hit_s     = 1'b0;
        evict_done_s = 1'b0;
        install_s    = 1'b0;
        fill_s       = mem_rdata;
        case (state_r)
            IDLE: begin
                if (cpu_rd || cpu_wr) begin
                    state_s = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    state_s  = IDLE;
                    rd_hit_s = !req_wr_r;
                    wr_hit_s = req_wr_r;
                end else if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
                    state_s = EVICT;
                end else begin
                    state_s = FETCH;
                end
            end
            EVICT: begin
                if (l2_wack) begin
                    evict_done_s = 1'b1;
                    state_s      = FETCH;
                end else begin
                    state_s = EVICT;
                end
            end
            FETCH: begin
                // l2_hit takes priority when both responses arrive together
                if (l2_hit) begin
                    install_s = 1'b1;
                    fill_s    = l2_rdata;
                    state_s   = LOOKUP;
                end else if (l2_miss) begin
                    state_s = MEMFILL;
                end else begin
                    state_s = FETCH;
                end
            end
            MEMFILL: begin
                if (mem_ack) begin
                    install_s = 1'b1;
                    fill_s    = mem_rdata;
                    state_s   = LOOKUP;
                end else begin
                    state_s = MEMFILL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Bus outputs decoded from the state register and the latched request only
    always_comb begin
        cpu_stall    = (state_r != IDLE);
        read_from_L2 = 1'b0;
        write_to_L2  = 1'b0;
        mem_req      = 1'b0;
        l2_addr      = 32'h0000_0000;
        l2_wdata     = 128'h0;
        mem_addr     = 32'h0000_0000;
        case (state_r)
            EVICT: begin
                write_to_L2 = 1'b1;
                l2_addr     = {tag_r[req_idx_s], req_idx_s, 2'b00};
                l2_wdata    = data_r[req_idx_s];
            end
            FETCH: begin
                read_from_L2 = 1'b1;
                l2_addr      = {req_addr_r[31:2], 2'b00};
            end
            MEMFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_addr_r[31:2], 2'b00};
            end
            default: begin
                read_from_L2 = 1'b0;
            end
        endcase
    end

    // State, latched request, line status bits and CPU-side response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            req_addr_r  <= 32'h0000_0000;
            req_wdata_r <= 32'h0000_0000;
            req_wr_r    <= 1'b0;
            valid_r     <= 16'h0000;
            dirty_r     <= 16'h0000;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= 32'h0000_0000;
        end else begin
            state_r   <= state_s;
            cpu_ready <= rd_hit_s | wr_hit_s;
            if (state_r == IDLE && (cpu_rd || cpu_wr)) begin
                req_addr_r  <= cpu_addr;
                req_wdata_r <= cpu_wdata;
                req_wr_r    <= !cpu_rd;
            end
            if (rd_hit_s) begin
                cpu_rdata <= data_r[req_idx_s][req_bit_s +: 32];
            end
            if (wr_hit_s) begin
                dirty_r[req_idx_s] <= 1'b1;
            end
            if (evict_done_s) begin
                valid_r[req_idx_s] <= 1'b0;
                dirty_r[req_idx_s] <= 1'b0;
            end
            if (install_s) begin
                valid_r[req_idx_s] <= 1'b1;
                dirty_r[req_idx_s] <= 1'b0;
            end
        end
    end

    // Tag and block storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (!reset && install_s) begin
            tag_r[req_idx_s]  <= req_tag_s;
            data_r[req_idx_s] <= fill_s;
        end else if (!reset && wr_hit_s) begin
            data_r[req_idx_s][req_bit_s +: 32] <= req_wdata_r;
        end
    end

`ifdef L1_STATS_EN
    logic first_pass_r;

    // Saturating hit/miss counters; the LOOKUP that follows a fill is not counted
    always_ff @(posedge clk) begin
        if (reset) begin
            first_pass_r <= 1'b0;
            hit_cnt      <= 16'h0000;
            miss_cnt     <= 16'h0000;
        end else begin
            if (state_r == IDLE && (cpu_rd || cpu_wr)) begin
                first_pass_r <= 1'b1;
            end else if (state_r == LOOKUP) begin
                first_pass_r <= 1'b0;
            end
            if (state_r == LOOKUP && first_pass_r && hit_s && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'h0001;
            end
            if (state_r == LOOKUP && first_pass_r && !hit_s && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl: directed accesses push the expected
// cpu_rdata into a queue; a monitor pops and compares on every cpu_ready.
// Define L1_STATS_EN to also exercise the hit/miss counters.
module tb_l1_cache_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_rd = 1'b0;
    logic         cpu_wr = 1'b0;
    logic [31:0]  cpu_addr = 32'h0;
    logic [31:0]  cpu_wdata = 32'h0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_stall;
    logic         read_from_L2;
    logic         write_to_L2;
    logic [31:0]  l2_addr;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata = 128'h0;
    logic         l2_hit = 1'b0;
    logic         l2_miss = 1'b0;
    logic         l2_wack = 1'b0;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_rdata = 128'h0;
    logic         mem_ack = 1'b0;
`ifdef L1_STATS_EN
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;
`endif

    int           n_checks = 0;
    int           n_fail = 0;
    int           ready_cnt = 0;
    int           exp_ready = 0;
    logic [31:0]  exp_q[$];
    logic         traffic_seen = 1'b0;
    logic         mem_seen = 1'b0;

    l1_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
        .read_from_L2(read_from_L2), .write_to_L2(write_to_L2),
        .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata),
        .l2_hit(l2_hit), .l2_miss(l2_miss), .l2_wack(l2_wack),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef L1_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on cpu_ready, plus bus exclusivity and traffic tracking
    always @(negedge clk) begin
        if (!reset) begin
            chk("bus_exclusive", 128'($countones({read_from_L2, write_to_L2, mem_req}) <= 1), 128'd1);
            if (read_from_L2 || write_to_L2 || mem_req) traffic_seen = 1'b1;
            if (mem_req) mem_seen = 1'b1;
            if (cpu_ready) begin
                ready_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 128'd1, 128'd0);
                end else begin
                    chk("sb_rdata", 128'(cpu_rdata), 128'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic expect_done(input logic [31:0] d);
        exp_q.push_back(d);
        exp_ready++;
    endtask

    // Returns at the negedge after the request was accepted (DUT in LOOKUP)
    task automatic drive_req(input logic rd, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_rd = rd; cpu_wr = !rd; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        #1;
        while (ready_cnt < exp_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (ready_cnt < exp_ready) chk({nm, "_timeout"}, 128'(ready_cnt), 128'(exp_ready));
    endtask

    task automatic pulse(input int which);
        if (which == 0) l2_wack = 1'b1;
        else if (which == 1) l2_hit = 1'b1;
        else if (which == 2) l2_miss = 1'b1;
        else mem_ack = 1'b1;
        @(negedge clk);
        l2_wack = 1'b0; l2_hit = 1'b0; l2_miss = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 128'(cpu_ready), 128'd0);
        chk("rst_stall", 128'(cpu_stall), 128'd0);
        chk("rst_rdata", 128'(cpu_rdata), 128'd0);
        chk("rst_strobes", 128'({read_from_L2, write_to_L2, mem_req}), 128'd0);
        chk("rst_addrs", 128'({l2_addr, mem_addr}), 128'd0);
        chk("rst_wdata", l2_wdata, 128'd0);
`ifdef L1_STATS_EN
        chk("rst_cnts", 128'({hit_cnt, miss_cnt}), 128'd0);
`endif

        // Cold read of 0x40: L2 miss, refill from memory
        expect_done(32'hA);
        drive_req(1'b1, 32'h40, 32'h0);
        chk("t1_stall", 128'(cpu_stall), 128'd1);
        @(negedge clk);
        chk("t1_fetch", 128'({read_from_L2, write_to_L2, mem_req}), 128'b100);
        chk("t1_l2_addr", 128'(l2_addr), 128'h40);
        pulse(2);
        chk("t1_memreq", 128'({read_from_L2, mem_req}), 128'b01);
        chk("t1_mem_addr", 128'(mem_addr), 128'h40);
        @(negedge clk);
        chk("t1_memreq_hold", 128'(mem_req), 128'd1);
        mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
        pulse(3);
        wait_ready("t1");
`ifdef L1_STATS_EN
        chk("t1_miss_cnt", 128'(miss_cnt), 128'd1);
        chk("t1_hit_cnt", 128'(hit_cnt), 128'd0);
`endif

        // Read hit 0x41: ready two cycles after the request
        expect_done(32'hB);
        drive_req(1'b1, 32'h41, 32'h0);
        @(negedge clk);
        chk("t2_latency", 128'(cpu_ready), 128'd1);
        chk("t2_rdata", 128'(cpu_rdata), 128'hB);
        wait_ready("t2");
`ifdef L1_STATS_EN
        chk("t2_hit_cnt", 128'(hit_cnt), 128'd1);
`endif

        // Write hit 0x43: no traffic, rdata holds previous load value
        traffic_seen = 1'b0;
        expect_done(32'hB);
        drive_req(1'b0, 32'h43, 32'hCAFEF00D);
        @(negedge clk);
        chk("t3_latency", 128'(cpu_ready), 128'd1);
        wait_ready("t3");
        chk("t3_no_traffic", 128'(traffic_seen), 128'd0);
        expect_done(32'hCAFEF00D);
        drive_req(1'b1, 32'h43, 32'h0);
        wait_ready("t3r");

        // Dirty victim: read 0x80 evicts tag 1 line, then L2 hit fill
        expect_done(32'h11);
        drive_req(1'b1, 32'h80, 32'h0);
        @(negedge clk);
        chk("t4_evict", 128'({read_from_L2, write_to_L2, mem_req}), 128'b010);
        chk("t4_evict_addr", 128'(l2_addr), 128'h40);
        chk("t4_evict_data", l2_wdata, {32'hCAFEF00D, 32'hC, 32'hB, 32'hA});
        @(negedge clk);
        chk("t4_evict_hold", 128'(write_to_L2), 128'd1);
        pulse(0);
        chk("t4_fetch", 128'({read_from_L2, write_to_L2}), 128'b10);
        chk("t4_fetch_addr", 128'(l2_addr), 128'h80);
        l2_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
        pulse(1);
        wait_ready("t4");

        // Clean victim dropped; l2_hit and l2_miss together -> l2_hit wins
        mem_seen = 1'b0;
        expect_done(32'h66);
        drive_req(1'b1, 32'h40, 32'h0);
        @(negedge clk);
        chk("t5_clean_drop", 128'({read_from_L2, write_to_L2}), 128'b10);
        chk("t5_fetch_addr", 128'(l2_addr), 128'h40);
        l2_rdata = {32'h99, 32'h88, 32'h77, 32'h66};
        l2_miss = 1'b1;
        pulse(1);
        wait_ready("t5");
        chk("t5_no_mem", 128'(mem_seen), 128'd0);

        // Reset during MEMFILL abandons the access
        drive_req(1'b1, 32'h100, 32'h0);
        @(negedge clk);
        pulse(2);
        chk("t6_memfill", 128'(mem_req), 128'd1);
        chk("t6_mem_addr", 128'(mem_addr), 128'h100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_memreq", 128'(mem_req), 128'd0);
        chk("t6_rst_stall", 128'(cpu_stall), 128'd0);
        chk("t6_rst_ready", 128'(cpu_ready), 128'd0);
        chk("t6_rst_rdata", 128'(cpu_rdata), 128'd0);
        expect_done(32'h5);
        drive_req(1'b1, 32'h100, 32'h0);
        @(negedge clk);
        chk("t6_miss_again", 128'(read_from_L2), 128'd1);
        l2_rdata = {32'h8, 32'h7, 32'h6, 32'h5};
        pulse(1);
        wait_ready("t6");
`ifdef L1_STATS_EN
        chk("t6_cnts", 128'({hit_cnt, miss_cnt}), 128'({16'd0, 16'd1}));

        // Hit counter saturation
        for (int i = 0; i < 70000; i++) begin
            expect_done(32'h5);
            drive_req(1'b1, 32'h100, 32'h0);
        end
        wait_ready("t7");
        chk("t7_hit_sat", 128'(hit_cnt), 128'hFFFF);
        chk("t7_miss_cnt", 128'(miss_cnt), 128'd1);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
